gemm_loop_sched: RTL and testbench

//  Three-level nested-loop scheduler for the GEMM engine. It walks the (i, j, k)

---
 rtl/gemm_loop_sched_if.sv | 40 ++++
 rtl/gemm_loop_sched.sv | 137 +++++++++++++
 tb/tb_gemm_loop_sched.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/gemm_loop_sched_if.sv
// Handshake/bus bundle between the control side and the GEMM loop scheduler.
// Optional perf counter signals appear when GEMM_SCHED_PERF_EN is defined.
//
// Handshake: start is a request sampled only while the scheduler is idle.
// en is the downstream ready, and valid marks a tuple issued this cycle.
// A tuple transfers on every cycle where valid=1. valid is only ever 1 together
// with en=1, so the control side never has to hold a tuple.
interface gemm_loop_sched_if #(
    parameter int W = 8
);
    logic         start;
    logic [W-1:0] m_fin;
    logic [W-1:0] n_fin;
    logic [W-1:0] k_fin;
    logic         en;
    logic [W-1:0] i;
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic         valid;
    logic         acc_clr;
    logic         acc_out;
    logic         busy;
    logic         done;
`ifdef GEMM_SCHED_PERF_EN
    logic [31:0]  stall_cnt;
    logic [31:0]  run_cnt;

    modport master (output start, m_fin, n_fin, k_fin, en,
                    input  i, j, k, valid, acc_clr, acc_out, busy, done,
                           stall_cnt, run_cnt);
    modport slave  (input  start, m_fin, n_fin, k_fin, en,
                    output i, j, k, valid, acc_clr, acc_out, busy, done,
                           stall_cnt, run_cnt);
`else
    modport master (output start, m_fin, n_fin, k_fin, en,
                    input  i, j, k, valid, acc_clr, acc_out, busy, done);
    modport slave  (input  start, m_fin, n_fin, k_fin, en,
                    output i, j, k, valid, acc_clr, acc_out, busy, done);
`endif
endinterface

// File: rtl/gemm_loop_sched.sv
// Three-level (i, j, k) nested-loop scheduler for the GEMM engine, k innermost.
// Issues one tuple per enabled cycle, flags first/last k of each output element,
// drains LAT enabled cycles after the last tuple and pulses done.
// Define GEMM_SCHED_PERF_EN to add the run_cnt / stall_cnt performance counters.
module gemm_loop_sched #(
    parameter int W   = 8,
    parameter int LAT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    gemm_loop_sched_if.slave      bus,
    output logic [1:0]            state_dbg
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    state_t        state;
    logic [W-1:0]  m_fin_q, n_fin_q, k_fin_q;
    logic [W-1:0]  i_q, j_q, k_q;
    logic [CW-1:0] drain_cnt;
    logic          k_last, j_last, i_last;

    assign k_last = (k_q == k_fin_q);
    assign j_last = (j_q == n_fin_q);
    assign i_last = (i_q == m_fin_q);

    // Outputs come only from registered state and en; start never reaches them.
    assign bus.i       = i_q;
    assign bus.j       = j_q;
    assign bus.k       = k_q;
    assign bus.valid   = (state == RUN) && bus.en;
    assign bus.acc_clr = bus.valid && (k_q == '0);
    assign bus.acc_out = bus.valid && k_last;
    assign bus.busy    = (state != IDLE);
    assign bus.done    = (state == DONE);
    assign state_dbg   = state;

    // Scheduler FSM: loop walk in RUN, enabled-cycle count in DRAIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            m_fin_q   <= '0;
            n_fin_q   <= '0;
            k_fin_q   <= '0;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        m_fin_q   <= bus.m_fin;
                        n_fin_q   <= bus.n_fin;
                        k_fin_q   <= bus.k_fin;
                        i_q       <= '0;
                        j_q       <= '0;
                        k_q       <= '0;
                        drain_cnt <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (bus.en) begin
                        if (!k_last) begin
                            k_q <= k_q + W'(1);
                        end else begin
                            k_q <= '0;
                            if (!j_last) begin
                                j_q <= j_q + W'(1);
                            end else begin
                                j_q <= '0;
                                if (!i_last) begin
                                    i_q <= i_q + W'(1);
                                end else begin
                                    // Final tuple issued: indices already back at 0.
                                    i_q       <= '0;
                                    drain_cnt <= '0;
                                    state     <= DRAIN;
                                end
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (bus.en) begin
                        if (drain_cnt == CW'(LAT - 1)) begin
                            drain_cnt <= '0;
                            state     <= DONE;
                        end else begin
                            drain_cnt <= drain_cnt + CW'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef GEMM_SCHED_PERF_EN
    logic [31:0] run_q, stall_q;

    assign bus.run_cnt   = run_q;
    assign bus.stall_cnt = stall_q;

    // Saturating busy / stalled-busy cycle counters, cleared by an accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q   <= '0;
            stall_q <= '0;
        end else if (state == IDLE) begin
            if (bus.start) begin
                run_q   <= '0;
                stall_q <= '0;
            end
        end else begin
            if (run_q != 32'hFFFF_FFFF) begin
                run_q <= run_q + 32'd1;
            end
            if (!bus.en && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_gemm_loop_sched.sv
// Directed testbench for gemm_loop_sched: a cycle table for the stalled run,
// plus hand-written sequences for restart, reset abort, minimal and wrap runs.
module tb_gemm_loop_sched;
    localparam int W   = 8;
    localparam int LAT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] state_dbg, state_dbg2;

    always #5 clk = ~clk;

    gemm_loop_sched_if #(.W(W)) bus ();
    gemm_loop_sched_if #(.W(2)) bus2 ();

    gemm_loop_sched #(.W(W), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .bus(bus), .state_dbg(state_dbg)
    );
    gemm_loop_sched #(.W(2), .LAT(LAT)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2), .state_dbg(state_dbg2)
    );

    typedef struct {
        logic       en;
        logic       valid;
        logic [7:0] i, j, k;
        logic       clr, out, busy, done;
    } vec_t;

    vec_t tbl [1:21];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(logic en, logic valid, logic [7:0] i, logic [7:0] j,
                                logic [7:0] k, logic clr, logic out, logic busy, logic done);
        vec_t v;
        v.en = en; v.valid = valid; v.i = i; v.j = j; v.k = k;
        v.clr = clr; v.out = out; v.busy = busy; v.done = done;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a run in the current cycle (c0) with en=1 held, then follow it to done.
    task automatic run_case(input logic [7:0] m, input logic [7:0] n, input logic [7:0] k,
                            input int done_at, input int pa, input int pb);
        logic [23:0] exp_q[$];
        logic [23:0] t;
        for (int a = 0; a <= int'(m); a++)
            for (int b = 0; b <= int'(n); b++)
                for (int c = 0; c <= int'(k); c++)
                    exp_q.push_back({a[7:0], b[7:0], c[7:0]});
        bus.m_fin = m; bus.n_fin = n; bus.k_fin = k;
        bus.en = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.m_fin = 8'($urandom_range(0, 255));
        bus.n_fin = 8'($urandom_range(0, 255));
        bus.k_fin = 8'($urandom_range(0, 255));
        for (int c = 1; c <= done_at; c++) begin
            bus.start = (c == pa) || (c == pb);
            @(negedge clk);
            chk("valid", bus.valid, exp_q.size() != 0);
            if (bus.valid && exp_q.size() != 0) begin
                t = exp_q.pop_front();
                chk("i", bus.i, t[23:16]);
                chk("j", bus.j, t[15:8]);
                chk("k", bus.k, t[7:0]);
                chk("acc_clr", bus.acc_clr, t[7:0] == 8'd0);
                chk("acc_out", bus.acc_out, t[7:0] == k);
            end
            chk("busy", bus.busy, 1);
            chk("done", bus.done, c == done_at);
            tick();
        end
        bus.start = 1'b0;
        chk("tuples_left", exp_q.size(), 0);
    endtask

    initial begin
        int got;

        // Case 3 table: m=1,n=1,k=2, stalls on c2..c4 and c14.
        tbl[1]  = mk(1, 1, 0, 0, 0, 1, 0, 1, 0);
        tbl[2]  = mk(0, 0, 0, 0, 1, 0, 0, 1, 0);
        tbl[3]  = mk(0, 0, 0, 0, 1, 0, 0, 1, 0);
        tbl[4]  = mk(0, 0, 0, 0, 1, 0, 0, 1, 0);
        tbl[5]  = mk(1, 1, 0, 0, 1, 0, 0, 1, 0);
        tbl[6]  = mk(1, 1, 0, 0, 2, 0, 1, 1, 0);
        tbl[7]  = mk(1, 1, 0, 1, 0, 1, 0, 1, 0);
        tbl[8]  = mk(1, 1, 0, 1, 1, 0, 0, 1, 0);
        tbl[9]  = mk(1, 1, 0, 1, 2, 0, 1, 1, 0);
        tbl[10] = mk(1, 1, 1, 0, 0, 1, 0, 1, 0);
        tbl[11] = mk(1, 1, 1, 0, 1, 0, 0, 1, 0);
        tbl[12] = mk(1, 1, 1, 0, 2, 0, 1, 1, 0);
        tbl[13] = mk(1, 1, 1, 1, 0, 1, 0, 1, 0);
        tbl[14] = mk(0, 0, 1, 1, 1, 0, 0, 1, 0);
        tbl[15] = mk(1, 1, 1, 1, 1, 0, 0, 1, 0);
        tbl[16] = mk(1, 1, 1, 1, 2, 0, 1, 1, 0);
        tbl[17] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[18] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[19] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[20] = mk(1, 0, 0, 0, 0, 0, 0, 1, 1);
        tbl[21] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset
        rst = 1'b1;
        bus.start = 1'b0; bus.en = 1'b0; bus.m_fin = '0; bus.n_fin = '0; bus.k_fin = '0;
        bus2.start = 1'b0; bus2.en = 1'b0; bus2.m_fin = '0; bus2.n_fin = '0; bus2.k_fin = '0;
        tick();
        tick();
        @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_valid", bus.valid, 0);
        chk("rst_ijk", {bus.i, bus.j, bus.k}, 0);
        chk("rst_state", state_dbg, 0);
`ifdef GEMM_SCHED_PERF_EN
        chk("rst_run_cnt", bus.run_cnt, 0);
        chk("rst_stall_cnt", bus.stall_cnt, 0);
`endif
        tick();
        rst = 1'b0;
        tick();

        // Case 1: plain run, done at c16
        run_case(8'd1, 8'd1, 8'd2, 16, -1, -1);
        tick();

        // Case 2: all fins zero, single tuple, done at c5
        run_case(8'd0, 8'd0, 8'd0, 5, -1, -1);
        tick();

        // Case 3: table-driven stalled run
        bus.m_fin = 8'd1; bus.n_fin = 8'd1; bus.k_fin = 8'd2;
        bus.en = 1'b1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= 21; c++) begin
            bus.en = tbl[c].en;
            @(negedge clk);
            chk($sformatf("t3_valid_c%0d", c), bus.valid, tbl[c].valid);
            chk($sformatf("t3_ijk_c%0d", c), {bus.i, bus.j, bus.k}, {tbl[c].i, tbl[c].j, tbl[c].k});
            chk($sformatf("t3_clr_c%0d", c), bus.acc_clr, tbl[c].clr);
            chk($sformatf("t3_out_c%0d", c), bus.acc_out, tbl[c].out);
            chk($sformatf("t3_busy_c%0d", c), bus.busy, tbl[c].busy);
            chk($sformatf("t3_done_c%0d", c), bus.done, tbl[c].done);
`ifdef GEMM_SCHED_PERF_EN
            if (c == 21) begin
                chk("t3_stall_cnt", bus.stall_cnt, 4);
                chk("t3_run_cnt", bus.run_cnt, 20);
            end
`endif
            tick();
        end
        bus.en = 1'b1;

        // Case 4: start pulses at c5 and c16 ignored, restart at c17
        run_case(8'd1, 8'd1, 8'd2, 16, 5, 16);
        @(negedge clk);
        chk("t4_idle_c17", bus.busy, 0);
        bus.m_fin = 8'd0; bus.n_fin = 8'd0; bus.k_fin = 8'd0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        @(negedge clk);
        chk("t4_valid_c18", bus.valid, 1);
        chk("t4_ijk_c18", {bus.i, bus.j, bus.k}, 0);
        tick();
        got = -1;
        for (int c = 19; c <= 30; c++) begin
            @(negedge clk);
            if (bus.done && got < 0) got = c;
            tick();
        end
        chk("t4_restart_done_cycle", got, 22);

        // Case 5: reset during c6 of case-1 run aborts, then a short run
        bus.m_fin = 8'd1; bus.n_fin = 8'd1; bus.k_fin = 8'd2;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        got = 0;
        for (int c = 1; c <= 6; c++) begin
            if (c == 6) rst = 1'b1;
            @(negedge clk);
            if (bus.done) got++;
            tick();
        end
        rst = 1'b0;
        @(negedge clk);
        chk("t5_busy_c7", bus.busy, 0);
        chk("t5_ijk_c7", {bus.i, bus.j, bus.k}, 0);
        chk("t5_done_c7", bus.done, 0);
        chk("t5_no_done_before", got, 0);
        tick();
        run_case(8'd0, 8'd0, 8'd1, 6, -1, -1);
        tick();

        // Case 6: W=2, fins at max -> 64 tuples, wrap to 0, done at c68
        bus2.m_fin = 2'd3; bus2.n_fin = 2'd3; bus2.k_fin = 2'd3;
        bus2.en = 1'b1; bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        for (int c = 1; c <= 69; c++) begin
            @(negedge clk);
            if (c <= 64) begin
                chk("t6_valid", bus2.valid, 1);
                chk("t6_i", bus2.i, (c - 1) / 16);
                chk("t6_j", bus2.j, ((c - 1) / 4) % 4);
                chk("t6_k", bus2.k, (c - 1) % 4);
                chk("t6_acc_out", bus2.acc_out, ((c - 1) % 4) == 3);
            end else if (c == 65) begin
                chk("t6_valid_after", bus2.valid, 0);
                chk("t6_wrap_ijk", {bus2.i, bus2.j, bus2.k}, 0);
            end
            chk("t6_done", bus2.done, c == 68);
            chk("t6_busy", bus2.busy, c <= 68);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
